// File: rtl/bus_rr_arbiter_bcast.sv
// Shared-bus generator/arbiter: moves one packet from an outbound FIFO to inbound FIFOs.
// Define BUS_BCAST_EN to deliver destination ID BCAST to every device except the source.
module bus_rr_arbiter_bcast #(
    parameter int         PCKG_SZ = 24,
    parameter int         DRVRS   = 16,
    parameter logic [7:0] BCAST   = 8'hFF,
    parameter int         MODE    = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DRVRS-1:0]         pndng,
    input  logic [DRVRS*PCKG_SZ-1:0] D_pop,
    output logic [DRVRS-1:0]         pop,
    output logic [DRVRS-1:0]         push,
    output logic [DRVRS*PCKG_SZ-1:0] D_push,
    output logic                     busy,
    output logic [7:0]               gnt_id,
    output logic                     drop
);
    localparam int PW = $clog2(DRVRS);
    localparam int IW = PW + 1;

    typedef enum logic [1:0] {IDLE, GRANT, DELIVER} state_t;

    state_t             state;
    logic [PW-1:0]      ptr;
    logic [PW-1:0]      src;
    logic [PW-1:0]      pick;
    logic [PW-1:0]      nxt;
    logic [IW-1:0]      idx;
    logic               found;
    logic [PCKG_SZ-1:0] pkt;
    logic [PCKG_SZ-1:0] pkt_in;
    logic [7:0]         id;
    logic [DRVRS-1:0]   mask;
    logic               ok;

    // Round-robin scans from ptr with wrap; fixed priority scans from 0.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < DRVRS; i++) begin
            if (MODE == 0) begin
                idx = {1'b0, ptr} + IW'(i);
                if (idx >= IW'(DRVRS))
                    idx = idx - IW'(DRVRS);
            end else begin
                idx = IW'(i);
            end
            if (!found && pndng[idx[PW-1:0]]) begin
                found = 1'b1;
                pick  = idx[PW-1:0];
            end
        end
    end

    assign nxt = (pick == PW'(DRVRS - 1)) ? '0 : pick + 1'b1;

    always_comb begin
        pkt_in = '0;
        for (int i = 0; i < DRVRS; i++)
            if (src == PW'(i))
                pkt_in = D_pop[i*PCKG_SZ +: PCKG_SZ];
    end

    assign id = pkt_in[PCKG_SZ-1 -: 8];

    always_comb begin
        mask = '0;
        ok   = 1'b0;
        if (int'(id) < DRVRS) begin
            ok = 1'b1;
            for (int i = 0; i < DRVRS; i++)
                mask[i] = (id == 8'(i));
        end
`ifdef BUS_BCAST_EN
        else if (id == BCAST) begin
            ok = 1'b1;
            for (int i = 0; i < DRVRS; i++)
                mask[i] = (src != PW'(i));
        end
`endif
    end

    assign D_push = {DRVRS{pkt}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            ptr    <= '0;
            src    <= '0;
            pkt    <= '0;
            pop    <= '0;
            push   <= '0;
            busy   <= 1'b0;
            gnt_id <= '0;
            drop   <= 1'b0;
        end else begin
            pop  <= '0;
            push <= '0;
            drop <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        src    <= pick;
                        gnt_id <= 8'(pick);
                        pop    <= DRVRS'(1) << pick;
                        busy   <= 1'b1;
                        state  <= GRANT;
                        if (MODE == 0)
                            ptr <= nxt;
                    end
                end
                GRANT: begin
                    pkt <= pkt_in;
                    if (ok) begin
                        push  <= mask;
                        state <= DELIVER;
                    end else begin
                        drop  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                DELIVER: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_rr_arbiter_bcast.sv
// Bench for bus_rr_arbiter_bcast: directed cases, then random traffic vs a FIFO/timeline model.
// Runs a round-robin instance and a fixed-priority instance side by side.
module tb_bus_rr_arbiter_bcast;
`ifdef BUS_BCAST_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  pndng [2];
    logic [63:0] dpop  [2];
    logic [3:0]  pop   [2];
    logic [3:0]  push  [2];
    logic [63:0] dpush [2];
    logic        busy  [2];
    logic [7:0]  gnt   [2];
    logic        drp   [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bus_rr_arbiter_bcast #(.PCKG_SZ(16), .DRVRS(4), .BCAST(8'hFF), .MODE(0)) u_rr (
        .clk(clk), .reset(reset), .pndng(pndng[0]), .D_pop(dpop[0]),
        .pop(pop[0]), .push(push[0]), .D_push(dpush[0]),
        .busy(busy[0]), .gnt_id(gnt[0]), .drop(drp[0])
    );

    bus_rr_arbiter_bcast #(.PCKG_SZ(16), .DRVRS(4), .BCAST(8'hFF), .MODE(1)) u_fp (
        .clk(clk), .reset(reset), .pndng(pndng[1]), .D_pop(dpop[1]),
        .pop(pop[1]), .push(push[1]), .D_push(dpush[1]),
        .busy(busy[1]), .gnt_id(gnt[1]), .drop(drp[1])
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // First requesting device, scanning from start (rr) or from 0 (fixed).
    function automatic int pick_dev(input logic [3:0] p, input int start, input bit fixed);
        for (int i = 0; i < 4; i++) begin
            int j;
            j = fixed ? i : (start + i) % 4;
            if (p[j]) return j;
        end
        return -1;
    endfunction

    // Model state for the random phase
    logic [15:0] q [8][$];
    logic [3:0]  e_pop  [8];
    logic [3:0]  e_push [8];
    logic        e_drop [8];
    logic        e_busy [8];
    int          ptr_m [2];
    int          free_at [2];
    int          deq_at [2];
    int          deq_src [2];
    logic [7:0]  m_gnt [2];
    logic [15:0] m_pkt [2];
    int          k, s, s1, s2, g, dev, r;
    bit          in_rst;
    logic [15:0] pk;
    logic [7:0]  idv;
    logic [3:0]  msk;
    int          gs [5];
    int          gc [5];
    int          n, cyc;

    initial begin
        reset = 1'b1;
        pndng[0] = '0; pndng[1] = '0;
        dpop[0] = '0;  dpop[1] = '0;
        tick(); tick();
        chk("rst pop", pop[0], 0);
        chk("rst push", push[0], 0);
        chk("rst busy", busy[0], 0);
        chk("rst gnt", gnt[0], 0);
        chk("rst drop", drp[0], 0);
        chk("rst dpush", dpush[0], 0);
        reset = 1'b0;

        // unicast 1 -> 2
        pndng[0] = 4'b0010; dpop[0][31:16] = 16'h02AB;
        tick();
        chk("uc pop", pop[0], 4'b0010);
        chk("uc busy1", busy[0], 1);
        chk("uc gnt", gnt[0], 1);
        chk("uc push0", push[0], 0);
        pndng[0] = 4'b0000;
        tick();
        chk("uc push", push[0], 4'b0100);
        chk("uc dpush", dpush[0][47:32], 16'h02AB);
        chk("uc pop0", pop[0], 0);
        chk("uc busy2", busy[0], 1);
        tick();
        chk("uc push end", push[0], 0);
        chk("uc busy end", busy[0], 0);

        // invalid ID from 0
        pndng[0] = 4'b0001; dpop[0][15:0] = 16'h0712;
        tick();
        chk("inv pop", pop[0], 4'b0001);
        chk("inv gnt", gnt[0], 0);
        pndng[0] = 4'b0000;
        tick();
        chk("inv drop", drp[0], 1);
        chk("inv push", push[0], 0);
        chk("inv busy", busy[0], 0);
        tick();
        chk("inv drop end", drp[0], 0);

        // broadcast from 2
        pndng[0] = 4'b0100; dpop[0][47:32] = 16'hFF55;
        tick();
        chk("bc pop", pop[0], 4'b0100);
        chk("bc gnt", gnt[0], 2);
        pndng[0] = 4'b0000;
        tick();
        if (BC) begin
            chk("bc push", push[0], 4'b1011);
            chk("bc dpush", dpush[0][15:0], 16'hFF55);
            chk("bc drop", drp[0], 0);
        end else begin
            chk("bc push", push[0], 4'b0000);
            chk("bc drop", drp[0], 1);
        end
        tick();

        // reset while delivering
        pndng[0] = 4'b0001; dpop[0][15:0] = 16'h0100;
        tick();
        chk("rd pop", pop[0], 4'b0001);
        pndng[0] = 4'b0000;
        tick();
        chk("rd push", push[0], 4'b0010);
        reset = 1'b1;
        #1;
        chk("rd push0", push[0], 0);
        chk("rd pop0", pop[0], 0);
        chk("rd busy0", busy[0], 0);
        chk("rd gnt0", gnt[0], 0);
        tick();
        reset = 1'b0;
        pndng[0] = 4'b0100; dpop[0][47:32] = 16'h0300;
        tick();
        chk("rd regrant pop", pop[0], 4'b0100);
        chk("rd regrant gnt", gnt[0], 2);
        pndng[0] = 4'b0000;
        tick(); tick();

        // RR fairness with all four requesting
        reset = 1'b1;
        tick();
        reset = 1'b0;
        dpop[0] = {16'h0203, 16'h0302, 16'h0001, 16'h0100};
        pndng[0] = 4'b1111;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (pop[0] != 0 && n < 5) begin
                gs[n] = int'(gnt[0]);
                gc[n] = c;
                n++;
            end
        end
        pndng[0] = 4'b0000;
        chk("rr count", 64'(n), 5);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("rr gnt%0d", i), 64'(gs[i]), 64'(i % 4));
            if (i > 0) chk($sformatf("rr gap%0d", i), 64'(gc[i] - gc[i-1]), 3);
        end
        tick(); tick();

        // fixed priority: 1 beats 3 until 1 stops requesting
        dpop[1] = {16'h0001, 16'h0000, 16'h0203, 16'h0000};
        pndng[1] = 4'b1010;
        n = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (pop[1] != 0 && n < 5) begin
                gs[n] = int'(gnt[1]);
                n++;
                if (n == 3) pndng[1] = 4'b1000;
            end
        end
        pndng[1] = 4'b0000;
        chk("fp count", 64'(n), 5);
        if (n >= 4) begin
            chk("fp g0", 64'(gs[0]), 1);
            chk("fp g1", 64'(gs[1]), 1);
            chk("fp g2", 64'(gs[2]), 1);
            chk("fp g3", 64'(gs[3]), 3);
        end
        tick(); tick();

        // random traffic against the model
        for (int i = 0; i < 8; i++) begin
            q[i].delete();
            e_pop[i] = 0; e_push[i] = 0; e_drop[i] = 0; e_busy[i] = 0;
        end
        for (int d = 0; d < 2; d++) begin
            ptr_m[d] = 0; free_at[d] = 0; deq_at[d] = -1;
            m_gnt[d] = 0; m_pkt[d] = 0; pndng[d] = 0;
        end
        reset = 1'b1;
        in_rst = 1'b1;
        k = 0;
        repeat (3000) begin
            tick();
            k++;
            for (int d = 0; d < 2; d++) begin
                s = d*4 + k%4;
                chk($sformatf("d%0d pop", d), pop[d], e_pop[s]);
                chk($sformatf("d%0d push", d), push[d], e_push[s]);
                chk($sformatf("d%0d drop", d), drp[d], e_drop[s]);
                chk($sformatf("d%0d busy", d), busy[d], e_busy[s]);
                chk($sformatf("d%0d gnt", d), gnt[d], m_gnt[d]);
                if (e_push[s] != 0)
                    chk($sformatf("d%0d dpush", d), dpush[d], {4{m_pkt[d]}});
                e_pop[s] = 0; e_push[s] = 0; e_drop[s] = 0; e_busy[s] = 0;
                if (deq_at[d] == k) begin
                    void'(q[d*4 + deq_src[d]].pop_front());
                    deq_at[d] = -1;
                end
            end
            if (in_rst) begin
                reset = 1'b0;
                in_rst = 1'b0;
            end else if ($urandom_range(0, 399) == 0) begin
                reset = 1'b1;
                in_rst = 1'b1;
                #1;
                for (int d = 0; d < 2; d++) begin
                    chk($sformatf("d%0d arst pop", d), pop[d], 0);
                    chk($sformatf("d%0d arst push", d), push[d], 0);
                    chk($sformatf("d%0d arst busy", d), busy[d], 0);
                    chk($sformatf("d%0d arst gnt", d), gnt[d], 0);
                    if (deq_at[d] > k) deq_at[d] = -1;
                    ptr_m[d] = 0; free_at[d] = k + 2; m_gnt[d] = 0;
                    for (int i = 0; i < 4; i++) begin
                        e_pop[d*4+i] = 0; e_push[d*4+i] = 0;
                        e_drop[d*4+i] = 0; e_busy[d*4+i] = 0;
                    end
                end
            end
            for (int d = 0; d < 2; d++) begin
                if ($urandom_range(0, 2) == 0) begin
                    dev = $urandom_range(0, 3);
                    r = $urandom_range(0, 9);
                    if (r < 7) idv = 8'($urandom_range(0, 3));
                    else if (r < 9) idv = 8'hFF;
                    else idv = 8'($urandom_range(4, 254));
                    if (q[d*4+dev].size() < 6)
                        q[d*4+dev].push_back({idv, 8'($urandom)});
                end
                msk = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
                for (int i = 0; i < 4; i++) begin
                    pndng[d][i] = (q[d*4+i].size() > 0) && msk[i];
                    dpop[d][i*16 +: 16] = (q[d*4+i].size() > 0) ? q[d*4+i][0] : 16'($urandom);
                end
            end
            if (!in_rst) begin
                for (int d = 0; d < 2; d++) begin
                    if (k + 1 >= free_at[d]) begin
                        g = pick_dev(pndng[d], ptr_m[d], d == 1);
                        if (g >= 0) begin
                            s1 = d*4 + (k+1)%4;
                            s2 = d*4 + (k+2)%4;
                            pk = q[d*4+g][0];
                            idv = pk[15:8];
                            e_pop[s1] = 4'(1 << g);
                            e_busy[s1] = 1;
                            m_gnt[d] = 8'(g);
                            m_pkt[d] = pk;
                            if (d == 0) ptr_m[d] = (g + 1) % 4;
                            deq_at[d] = k + 2;
                            deq_src[d] = g;
                            if (idv < 4) begin
                                e_push[s2] = 4'(1 << idv);
                                e_busy[s2] = 1;
                                free_at[d] = k + 4;
                            end else if (idv == 8'hFF && BC) begin
                                e_push[s2] = 4'hF & ~4'(1 << g);
                                e_busy[s2] = 1;
                                free_at[d] = k + 4;
                            end else begin
                                e_drop[s2] = 1;
                                free_at[d] = k + 3;
                            end
                        end
                    end
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
